// File: rtl/pe_pkg.sv
// pe_pkg -- shared definitions for the PE datapath.
//
// Contents:
//   PE_BITWIDTH              default operand width per lane
//   `PE_LANE_LO(i, w)        low bit index of lane i in a packed bus of w-bit lanes
//   `PE_LANE_HI(i, w)        high bit index of lane i in the same packing
//   pe_umax(w)               largest unsigned value representable in w bits
//   pe_smax(w) / pe_smin(w)  largest / smallest two's complement value in w bits
//
// The min/max helpers are constant functions, so they can size saturation
// constants from a module parameter at elaboration time.

`ifndef PE_PKG_LANE_MACROS
`define PE_PKG_LANE_MACROS
`define PE_LANE_LO(i, w) ((i) * (w))
`define PE_LANE_HI(i, w) (((i) + 1) * (w) - 1)
`endif

package pe_pkg;

  localparam int PE_BITWIDTH = 8;

  function automatic longint pe_umax(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint pe_smax(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint pe_smin(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/pe_lane_add.sv
// pe_lane_add -- one lane of the PE adder, purely combinational.
//
// Extends both operands to the result width (sign- or zero-extension chosen
// by mode_s), then produces either a plain sum or an accumulate step.
// The accumulate path is computed one bit wider than the result so that
// overflow against the mode's range can be detected exactly.
//
// Configuration macro: PE_ADDER_SAT_EN
//   defined   -> accumulate overflow clamps to the min/max of the mode's range
//   undefined -> accumulate overflow wraps modulo 2^OUTW
//   Plain adds are exact and never affected.
//
// Ports:
//   mode_s   in   1          1: signed operands, 0: unsigned
//   acc_en   in   1          1: result = acc + a (b ignored), 0: result = a + b
//   acc_clr  in   1          treat the accumulator as zero for this step
//   a, b     in   BITWIDTH   lane operands
//   acc      in   OUTW       current accumulator value of this lane
//   result   out  OUTW       lane result (also the next accumulator when acc_en)
//   ovf      out  1          accumulate result did not fit the mode's range

module pe_lane_add
  import pe_pkg::*;
#(
  parameter int BITWIDTH = PE_BITWIDTH
) (
  input  logic                mode_s,
  input  logic                acc_en,
  input  logic                acc_clr,
  input  logic [BITWIDTH-1:0] a,
  input  logic [BITWIDTH-1:0] b,
  input  logic [BITWIDTH:0]   acc,
  output logic [BITWIDTH:0]   result,
  output logic                ovf
);

  localparam int OUTW = BITWIDTH + 1;
  localparam int ACCW = OUTW + 1;

`ifdef PE_ADDER_SAT_EN
  localparam logic [OUTW-1:0] U_MAX = OUTW'(pe_umax(OUTW));
  localparam logic [OUTW-1:0] S_MAX = OUTW'(pe_smax(OUTW));
  localparam logic [OUTW-1:0] S_MIN = OUTW'(pe_smin(OUTW));
`endif

  logic [ACCW-1:0] ext_a;
  logic [OUTW-1:0] ext_b;
  logic [ACCW-1:0] acc_base;
  logic [ACCW-1:0] acc_sum;
  logic [OUTW-1:0] plain_sum;
  logic            acc_ovf;
  logic [OUTW-1:0] acc_res;

  // Operand extension. The accumulator is re-extended under the current
  // beat's mode, so mixing modes simply reinterprets the stored bits.
  always_comb begin
    ext_a    = {{2{mode_s & a[BITWIDTH-1]}}, a};
    ext_b    = {mode_s & b[BITWIDTH-1], b};
    acc_base = acc_clr ? '0 : {mode_s & acc[OUTW-1], acc};
  end

  // Both sums. The plain sum cannot overflow because OUTW has one bit of
  // headroom over the operands. For the accumulate sum the extra top bit
  // tells us whether the true value left the OUTW range: unsigned results
  // are never negative, so a set top bit means too large; signed results
  // are out of range when the top two bits disagree.
  always_comb begin
    plain_sum = ext_a[OUTW-1:0] + ext_b;
    acc_sum   = acc_base + ext_a;
    acc_ovf   = mode_s ? (acc_sum[ACCW-1] ^ acc_sum[OUTW-1]) : acc_sum[ACCW-1];
  end

  // Overflow handling. With saturation the sign of the wide sum picks the
  // clamp direction in signed mode; unsigned can only overflow upwards.
  always_comb begin
    acc_res = acc_sum[OUTW-1:0];
`ifdef PE_ADDER_SAT_EN
    if (acc_ovf) begin
      if (mode_s) begin
        acc_res = acc_sum[ACCW-1] ? S_MIN : S_MAX;
      end else begin
        acc_res = U_MAX;
      end
    end
`endif
  end

  // Lane output select.
  always_comb begin
    result = acc_en ? acc_res : plain_sum;
    ovf    = acc_en & acc_ovf;
  end

endmodule

// File: rtl/pe_pipe_adder.sv
// pe_pipe_adder -- pipelined multi-lane adder for the PE datapath.
//
// Each accepted beat carries LANES independent adds. Stage 1 registers the
// operands and control bits, stage 2 registers the computed lane results.
// A beat accepted on one clock edge is presented on out_valid after the
// following edge. Valid/ready handshakes on both sides with full
// backpressure; per-lane accumulators advance when a beat moves from
// stage 1 into stage 2, so back-to-back accumulate beats chain correctly.
//
// Configuration macro: PE_ADDER_SAT_EN (see pe_lane_add) selects saturating
// instead of wrapping accumulate overflow.
//
// Ports:
//   clk        in   1               clock, all state on rising edge
//   rst_n      in   1               synchronous reset, active-low
//   in_valid   in   1               input beat valid
//   in_ready   out  1               beat accepted when in_valid && in_ready
//   mode_s     in   1               1: signed, 0: unsigned
//   acc_en     in   1               1: accumulate din1, 0: din1 + din2
//   acc_clr    in   1               zero accumulators before this beat's add
//   din1       in   LANES*BITWIDTH  lane i at [i*BITWIDTH +: BITWIDTH]
//   din2       in   LANES*BITWIDTH  same packing
//   out_valid  out  1               result beat valid
//   out_ready  in   1               result consumed when out_valid && out_ready
//   dout       out  LANES*OUTW      lane i at [i*OUTW +: OUTW]
//   ovf        out  LANES           per-lane accumulate overflow

module pe_pipe_adder
  import pe_pkg::*;
#(
  parameter int BITWIDTH = PE_BITWIDTH,
  parameter int LANES    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode_s,
  input  logic                          acc_en,
  input  logic                          acc_clr,
  input  logic [LANES*BITWIDTH-1:0]     din1,
  input  logic [LANES*BITWIDTH-1:0]     din2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*(BITWIDTH+1)-1:0] dout,
  output logic [LANES-1:0]              ovf
);

  localparam int OUTW = BITWIDTH + 1;

  logic                      s1_valid;
  logic                      s1_mode;
  logic                      s1_acc_en;
  logic                      s1_acc_clr;
  logic [LANES*BITWIDTH-1:0] s1_din1;
  logic [LANES*BITWIDTH-1:0] s1_din2;

  logic [LANES*OUTW-1:0]     acc_q;
  logic [LANES*OUTW-1:0]     lane_res;
  logic [LANES-1:0]          lane_ovf;

  logic                      s2_advance;
  logic                      s1_move;
  logic                      accept;

  // Handshake. Stage 2 can take a new beat when it is empty or its beat is
  // being consumed this cycle; stage 1 can take a new beat when it is empty
  // or its beat is moving on. in_ready therefore depends combinationally
  // on out_ready, which is what lets the pipe sustain one beat per cycle.
  always_comb begin
    s2_advance = !out_valid || out_ready;
    s1_move    = s1_valid && s2_advance;
    in_ready   = !s1_valid || s2_advance;
    accept     = in_valid && in_ready;
  end

  // Stage 1: capture the beat. When in_ready is low the stage holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_mode    <= 1'b0;
      s1_acc_en  <= 1'b0;
      s1_acc_clr <= 1'b0;
      s1_din1    <= '0;
      s1_din2    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_mode    <= mode_s;
        s1_acc_en  <= acc_en;
        s1_acc_clr <= acc_clr;
        s1_din1    <= din1;
        s1_din2    <= din2;
      end
    end
  end

  // Per-lane datapath, fed from the stage 1 registers and the accumulators.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    pe_lane_add #(
      .BITWIDTH (BITWIDTH)
    ) u_lane (
      .mode_s  (s1_mode),
      .acc_en  (s1_acc_en),
      .acc_clr (s1_acc_clr),
      .a       (s1_din1[`PE_LANE_HI(gi, BITWIDTH):`PE_LANE_LO(gi, BITWIDTH)]),
      .b       (s1_din2[`PE_LANE_HI(gi, BITWIDTH):`PE_LANE_LO(gi, BITWIDTH)]),
      .acc     (acc_q[`PE_LANE_HI(gi, OUTW):`PE_LANE_LO(gi, OUTW)]),
      .result  (lane_res[`PE_LANE_HI(gi, OUTW):`PE_LANE_LO(gi, OUTW)]),
      .ovf     (lane_ovf[gi])
    );
  end

  // Accumulators update exactly once per beat, as it leaves stage 1. An
  // accumulate beat stores the lane result (already clamped when saturating);
  // a plain beat with acc_clr only zeroes them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (s1_move) begin
      if (s1_acc_en) begin
        acc_q <= lane_res;
      end else if (s1_acc_clr) begin
        acc_q <= '0;
      end
    end
  end

  // Stage 2: the output register. It only changes when it may advance, so
  // the presented data is stable for as long as the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= '0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        dout <= lane_res;
        ovf  <= lane_ovf;
      end
    end
  end

endmodule

// File: tb/tb_pe_pipe_adder.sv
// tb_pe_pipe_adder -- scoreboard bench for pe_pipe_adder (BITWIDTH=8, LANES=2).
//
// Stimulus tasks push the hand-computed expected result of each beat when
// it is accepted; an independent monitor compares whatever the DUT presents
// against the head of the queue every cycle out_valid is high, and pops it
// when the beat is consumed. Expected values follow PE_ADDER_SAT_EN.

module tb_pe_pipe_adder;

  typedef struct {
    logic [17:0] dout;
    logic [1:0]  ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode_s;
  logic        acc_en;
  logic        acc_clr;
  logic [15:0] din1;
  logic [15:0] din2;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] dout;
  logic [1:0]  ovf;

  exp_t  sb[$];
  int    total;
  int    bad;
  int    n_in;
  int    n_out;
  logic  saw_in_ready_low;
  string cur_test;

  pe_pipe_adder #(
    .BITWIDTH (8),
    .LANES    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode_s    (mode_s),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .din1      (din1),
    .din2      (din2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .ovf       (ovf)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one beat and wait (bounded) until the DUT accepts it; the
  // expected response is queued at the cycle of acceptance.
  task automatic applyStimulus(input logic m, input logic ae, input logic ac,
                               input logic [15:0] d1, input logic [15:0] d2,
                               input logic [17:0] exp_dout, input logic [1:0] exp_ovf);
    exp_t e;
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    mode_s   = m;
    acc_en   = ae;
    acc_clr  = ac;
    din1     = d1;
    din2     = d2;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      saw_in_ready_low = 1'b1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("[TB] FAIL %s accept_timeout: in_ready got 0 expected 1", cur_test);
    end else begin
      e.dout = exp_dout;
      e.ovf  = exp_ovf;
      sb.push_back(e);
      n_in++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for every queued beat to come out.
  task automatic drainPipe();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s drain_timeout: pending got %0d expected 0", cur_test, sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the presented beat every cycle it is valid, which also
  // checks that the data holds steady through a stall.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s unexpected_beat: got dout 0x%0h expected no beat", cur_test, dout);
      end else begin
        checkOutput({cur_test, " dout"}, 64'(dout), 64'(sb[0].dout));
        checkOutput({cur_test, " ovf"}, 64'(ovf), 64'(sb[0].ovf));
        if (out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    n_in = 0;
    n_out = 0;
    saw_in_ready_low = 1'b0;
    cur_test = "reset";
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    mode_s = 1'b0;
    acc_en = 1'b0;
    acc_clr = 1'b0;
    din1 = '0;
    din2 = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset dout", 64'(dout), 64'd0);
    checkOutput("reset ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);

    // Test 1: unsigned plain add, plus the two-edge latency.
    cur_test = "t1";
    applyStimulus(1'b0, 1'b0, 1'b0, {8'd255, 8'd200}, {8'd255, 8'd34},
                  {9'h1FE, 9'd234}, 2'b00);
    checkOutput("t1 lat_s1", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("t1 lat_s2", 64'(out_valid), 64'd1);
    drainPipe();

    // Test 2: signed plain add.
    cur_test = "t2";
    applyStimulus(1'b1, 1'b0, 1'b0, {8'h7F, 8'hFD}, {8'h80, 8'hFC},
                  {9'h1FF, 9'h1F9}, 2'b00);
    applyStimulus(1'b1, 1'b0, 1'b0, {8'h03, 8'h03}, {8'h04, 8'hFC},
                  {9'h007, 9'h1FF}, 2'b00);
    drainPipe();

    // Test 3: six back-to-back beats with the consumer stalled for five cycles.
    cur_test = "t3";
    saw_in_ready_low = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          applyStimulus(1'b0, 1'b0, 1'b0, {8'(10 * k), 8'(k)}, {8'd1, 8'd1},
                        {9'(10 * k + 1), 9'(k + 1)}, 2'b00);
        end
      end
      begin
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drainPipe();
    checkOutput("t3 in_ready_dropped", 64'(saw_in_ready_low), 64'd1);

    // Test 4: unsigned accumulate past the top of the range.
    cur_test = "t4";
    applyStimulus(1'b0, 1'b1, 1'b1, {8'd1, 8'd200}, 16'd0, {9'd1, 9'd200}, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, {8'd1, 8'd200}, 16'd0, {9'd2, 9'd400}, 2'b00);
`ifdef PE_ADDER_SAT_EN
    applyStimulus(1'b0, 1'b1, 1'b0, {8'd1, 8'd200}, 16'd0, {9'd3, 9'd511}, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, {8'd1, 8'd1}, 16'd0, {9'd4, 9'd511}, 2'b01);
`else
    applyStimulus(1'b0, 1'b1, 1'b0, {8'd1, 8'd200}, 16'd0, {9'd3, 9'd88}, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, {8'd1, 8'd1}, 16'd0, {9'd4, 9'd89}, 2'b00);
`endif
    drainPipe();

    // Test 5: signed accumulate past both ends of the range.
    cur_test = "t5";
    applyStimulus(1'b1, 1'b1, 1'b1, {8'h7F, 8'h80}, 16'd0, {9'h07F, 9'h180}, 2'b00);
    applyStimulus(1'b1, 1'b1, 1'b0, {8'h7F, 8'h80}, 16'd0, {9'h0FE, 9'h100}, 2'b00);
`ifdef PE_ADDER_SAT_EN
    applyStimulus(1'b1, 1'b1, 1'b0, {8'h7F, 8'h80}, 16'd0, {9'h0FF, 9'h100}, 2'b11);
`else
    applyStimulus(1'b1, 1'b1, 1'b0, {8'h7F, 8'h80}, 16'd0, {9'h17D, 9'h080}, 2'b11);
`endif
    drainPipe();

    // Test 6: reset with two accumulate beats in flight.
    cur_test = "t6";
    applyStimulus(1'b0, 1'b1, 1'b1, {8'd7, 8'd100}, 16'd0, {9'd7, 9'd100}, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, {8'd7, 8'd50}, 16'd0, {9'd14, 9'd150}, 2'b00);
    rst_n = 1'b0;
    n_in = n_in - sb.size();
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("t6 out_valid", 64'(out_valid), 64'd0);
    checkOutput("t6 dout", 64'(dout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 1'b0, {8'd0, 8'd5}, 16'd0, {9'd0, 9'd5}, 2'b00);
    drainPipe();

    cur_test = "end";
    checkOutput("beat_count", 64'(n_out), 64'(n_in));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
